// File: rtl/video_pkg.sv
// Shared video-path types and screen geometry for the drawing/VGA blocks.
package video_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 18;
  localparam int ADDR_W   = 15;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_entry_t;

  // y*160 + x built from shifts: y*128 + y*32 + x
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is held in a register so dout is flop-driven.
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     dout_vld,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] head_q, head_d;
  logic          vld_q, vld_d;
  logic          push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_ok   = pop && vld_q;
  // a pop frees a slot in the same cycle, so push into a full FIFO is fine then
  assign push_ok  = push && (!full || pop_ok);
  assign dout     = head_q;
  assign dout_vld = vld_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    vld_d    = (wr_ptr_d != rd_ptr_d);
    head_d   = head_q;
    if (pop_ok)
      head_d = (push_ok && rd_ptr_d == wr_ptr_q) ? din : mem[rd_ptr_d[AW-1:0]];
    else if (!vld_q && push_ok)
      head_d = din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clock)
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
endmodule

// File: rtl/pixel_write_sink.sv
// Range-checks drawer pixel writes, linearises (x,y) and queues them for the framebuffer port.
module pixel_write_sink
  import video_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = SCREEN_W,
  parameter int unsigned HEIGHT = SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      vga_x,
  input  logic [Y_W-1:0]      vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_write,
  output logic                busy,
  output logic                idle,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_we,
  input  logic                fb_ready,
  output logic [7:0]          drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] BUSY_LVL = (AW+1)'(DEPTH-1);

  pixel_entry_t in_entry_q, in_entry_d, head;
  logic         in_vld_q, in_vld_d;
  logic [7:0]   drop_count_q, drop_count_d;
  logic [8:0]   drop_sum;
  logic         in_range, range_drop, ovf_drop, pop;
  logic         fifo_full, fifo_empty, fifo_vld;
  logic [AW:0]  fifo_count;

  assign pop = fb_we && fb_ready;

  always_comb begin
    in_range          = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    range_drop        = vga_write && !in_range;
    in_vld_d          = vga_write && in_range;
    in_entry_d.addr   = pix_addr(vga_x, vga_y);
    in_entry_d.colour = vga_colour;
    // only reachable when a driver ignored busy
    ovf_drop          = in_vld_q && fifo_full && !pop;
    drop_sum          = {1'b0, drop_count_q} + {8'd0, range_drop} + {8'd0, ovf_drop};
    drop_count_d      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_vld_q     <= 1'b0;
      in_entry_q   <= '0;
      drop_count_q <= '0;
    end else begin
      in_vld_q     <= in_vld_d;
      in_entry_q   <= in_entry_d;
      drop_count_q <= drop_count_d;
    end
  end

  sync_fifo #(.DW($bits(pixel_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_vld_q),
    .din      (in_entry_q),
    .pop      (pop),
    .dout     (head),
    .dout_vld (fifo_vld),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fb_addr    = head.addr;
  assign fb_data    = head.colour;
  assign fb_we      = fifo_vld;
  assign busy       = (fifo_count >= BUSY_LVL);
  assign idle       = fifo_empty && !fb_we && !in_vld_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: expected fb writes queued at drive time, popped on fb accept.
module tb_pixel_write_sink;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [17:0] vga_colour = '0;
  logic        vga_write = 1'b0;
  logic        busy, idle, fb_we;
  logic [14:0] fb_addr;
  logic [17:0] fb_data;
  logic        fb_ready = 1'b1;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int exp_drop = 0;
  logic [32:0] sb[$];

  logic        prev_stall = 1'b0;
  logic [32:0] prev_ent;

  pixel_write_sink dut (
    .clock(clock), .reset(reset), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_write(vga_write), .busy(busy), .idle(idle),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // accepted fb writes are consumed at the next rising edge
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (fb_we !== 1'b1 || {fb_addr, fb_data} !== prev_ent) begin
          errors++;
          $display("FAIL stall_hold: got we=%b ent=%h, want we=1 ent=%h", fb_we, {fb_addr, fb_data}, prev_ent);
        end
      end
      if (fb_we && fb_ready) begin
        checks++;
        n_wr++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", fb_addr, fb_data);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({fb_addr, fb_data} !== e) begin
            errors++;
            $display("FAIL sb_order: got addr=%0d data=%h, want addr=%0d data=%h",
                     fb_addr, fb_data, e[32:18], e[17:0]);
          end
        end
      end
      prev_stall = fb_we && !fb_ready;
      prev_ent   = {fb_addr, fb_data};
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic bump_drop();
    exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
  endtask

  // one write strobe for one cycle; accept=0 models an overflow drop
  task automatic put(input int x, input int y, input logic [17:0] c, input bit accept);
    logic [14:0] a;
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_write = 1'b1;
    a = 15'(x + 160 * y);
    if (x < 160 && y < 120 && accept) sb.push_back({a, c});
    else bump_drop();
    step();
    vga_write = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((sb.size() != 0 || !idle) && n < limit) begin step(); n++; end
    checks++;
    if (sb.size() != 0 || !idle) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending idle=%b, want 0 pending idle=1", name, sb.size(), idle);
    end
  endtask

  task automatic chk_drop(input string name);
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL %s_drop: got %0d, want %0d", name, drop_count, exp_drop);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({fb_we, fb_addr, fb_data, drop_count, busy, idle} !== {1'b0, 15'd0, 18'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h drop=%0d busy=%b idle=%b, want 0/0/0/0/0/1",
               fb_we, fb_addr, fb_data, drop_count, busy, idle);
    end
  endtask

  task automatic test_single();
    int w0 = n_wr;
    fb_ready = 1'b1;
    put(5, 2, 18'h3FFFF, 1'b1);
    checks++;
    if (fb_we !== 1'b0 || idle !== 1'b0) begin
      errors++; $display("FAIL single_c1: got we=%b idle=%b, want we=0 idle=0", fb_we, idle);
    end
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd325 || fb_data !== 18'h3FFFF) begin
      errors++; $display("FAIL single_c2: got we=%b addr=%0d data=%h, want 1/325/3ffff", fb_we, fb_addr, fb_data);
    end
    step();
    checks++;
    if (fb_we !== 1'b0 || idle !== 1'b1 || n_wr - w0 != 1) begin
      errors++; $display("FAIL single_c3: got we=%b idle=%b writes=%0d, want 0/1/1", fb_we, idle, n_wr - w0);
    end
  endtask

  task automatic test_corners();
    int w0 = n_wr;
    put(0, 0, 18'h00001, 1'b1);
    put(159, 119, 18'h2AAAA, 1'b1);
    put(160, 0, 18'h11111, 1'b1);
    put(0, 120, 18'h22222, 1'b1);
    drain("corners", 20);
    chk_drop("corners");
    checks++;
    if (n_wr - w0 != 2) begin
      errors++; $display("FAIL corners_count: got %0d writes, want 2", n_wr - w0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    fb_ready = 1'b0;
    for (int i = 0; i < 7; i++) put(10 + i, 3 * i, 18'(i * 4099 + 7), 1'b1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy6: got %b, want 0", busy); end
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy7: got %b, want 1", busy); end
    step(); step(); step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd10) begin
      errors++; $display("FAIL bp_head: got we=%b addr=%0d, want we=1 addr=10", fb_we, fb_addr);
    end
    fb_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drop: got %b, want 0", busy); end
    put(99, 99, 18'h15555, 1'b1);
    while (fb_we && n < 20) begin step(); n++; end
    checks++;
    if (n != 6) begin errors++; $display("FAIL bp_rate: got %0d stream cycles, want 6", n); end
    drain("bp", 20);
    chk_drop("bp");
  endtask

  task automatic test_stream();
    int w0 = n_wr;
    bit seen_busy = 1'b0;
    fb_ready = 1'b1;
    for (int k = 0; k < 120; k++) begin
      put(40, k, 18'(k * 1000 + 3), 1'b1);
      if (busy) seen_busy = 1'b1;
    end
    drain("stream", 20);
    checks++;
    if (seen_busy || n_wr - w0 != 120) begin
      errors++; $display("FAIL stream: got busy_seen=%b writes=%0d, want 0/120", seen_busy, n_wr - w0);
    end
  endtask

  task automatic test_overflow();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) put(i, 50, 18'(i + 16'hA00), i < 8);
    step(); step();
    chk_drop("ovf");
    fb_ready = 1'b1;
    drain("ovf", 30);
    for (int i = 0; i < 300; i++) put(200, 5, 18'h0, 1'b1);
    step();
    checks++;
    if (drop_count !== 8'd255 || exp_drop != 255) begin
      errors++; $display("FAIL sat_drop: got %0d, want 255", drop_count);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(20 + i, 7, 18'(i + 1), 1'b1);
    step();
    checks++;
    if (fb_we !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ar_pre: got we=%b busy=%b, want 1/0", fb_we, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fb_we, fb_addr, fb_data, drop_count, busy, idle} !== {1'b0, 15'd0, 18'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ar_clear: got we=%b addr=%0d data=%h drop=%0d busy=%b idle=%b, want 0/0/0/0/0/1",
               fb_we, fb_addr, fb_data, drop_count, busy, idle);
    end
    sb.delete();
    exp_drop = 0;
    step(); step();
    #2 reset = 1'b0;
    fb_ready = 1'b1;
    w0 = n_wr;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (n_wr != w0 || fb_we !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL ar_post: got writes=%0d we=%b idle=%b, want 0/0/1", n_wr - w0, fb_we, idle);
    end
  endtask

  initial begin
    step(); step();
    test_reset();
    #2 reset = 1'b0;
    step();
    test_single();
    test_corners();
    test_backpressure();
    test_stream();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
